// File: rtl/dram_axi_responder.sv
// AXI4-Lite DRAM model: one outstanding transaction, 64-bit word array, programmable response latency.
// Define DRAM_RAND_LAT_EN to draw each transaction's latency (1..8) from an 8-bit LFSR instead of LAT.
module dram_axi_responder #(
    parameter int          DEPTH = 256,
    parameter logic [16:0] BASE  = 17'h10000,
    parameter int          LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        AR_VALID,
    input  logic [16:0] AR_ADDR,
    output logic        AR_READY,
    output logic        R_VALID,
    output logic [63:0] R_DATA,
    output logic [1:0]  R_RESP,
    input  logic        R_READY,
    input  logic        AW_VALID,
    input  logic [16:0] AW_ADDR,
    output logic        AW_READY,
    input  logic        W_VALID,
    input  logic [63:0] W_DATA,
    output logic        W_READY,
    output logic        B_VALID,
    output logic [1:0]  B_RESP,
    input  logic        B_READY
);
    localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [17:0] SPAN = 18'(8 * DEPTH);

    typedef enum logic [2:0] {
        IDLE, AR_ACK, R_LAT, R_OUT, AW_ACK, W_ACK, W_LAT, B_OUT
    } state_t;

    state_t        state;
    logic [16:0]   addr_q;
    logic [16:0]   off;
    logic [3:0]    cnt;
    logic [3:0]    wlat;
    logic [3:0]    lat_m1;
    logic          legal;
    logic          we;
    logic [IW-1:0] idx;
    logic [63:0]   mem [DEPTH];

    assign off   = addr_q - BASE;
    assign legal = (addr_q >= BASE) && ({1'b0, off} < SPAN) && (addr_q[2:0] == 3'b000);
    assign idx   = off[IW+2:3];
    assign we    = (state == W_ACK) && W_VALID && legal;

`ifdef DRAM_RAND_LAT_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= 8'hA5;
        else if (state == AR_ACK || state == AW_ACK)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign lat_m1 = {1'b0, lfsr[2:0]};
`else
    assign lat_m1 = 4'(LAT - 1);
`endif

    // Array is deliberately outside the reset domain: contents survive rst like real DRAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= W_DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            cnt      <= '0;
            wlat     <= '0;
            AR_READY <= 1'b0;
            R_VALID  <= 1'b0;
            R_DATA   <= '0;
            R_RESP   <= 2'b00;
            AW_READY <= 1'b0;
            W_READY  <= 1'b0;
            B_VALID  <= 1'b0;
            B_RESP   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (AR_VALID) begin
                        state    <= AR_ACK;
                        AR_READY <= 1'b1;
                    end else if (AW_VALID) begin
                        state    <= AW_ACK;
                        AW_READY <= 1'b1;
                    end
                end
                AR_ACK: begin
                    AR_READY <= 1'b0;
                    addr_q   <= AR_ADDR;
                    cnt      <= lat_m1;
                    state    <= R_LAT;
                end
                R_LAT: begin
                    if (cnt == 4'd0) begin
                        R_VALID <= 1'b1;
                        R_RESP  <= legal ? 2'b00 : 2'b10;
                        R_DATA  <= legal ? mem[idx] : 64'd0;
                        state   <= R_OUT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                R_OUT: begin
                    if (R_READY) begin
                        R_VALID <= 1'b0;
                        state   <= IDLE;
                    end
                end
                AW_ACK: begin
                    AW_READY <= 1'b0;
                    addr_q   <= AW_ADDR;
                    wlat     <= lat_m1;
                    W_READY  <= 1'b1;
                    state    <= W_ACK;
                end
                W_ACK: begin
                    if (W_VALID) begin
                        W_READY <= 1'b0;
                        cnt     <= wlat;
                        state   <= W_LAT;
                    end
                end
                W_LAT: begin
                    if (cnt == 4'd0) begin
                        B_VALID <= 1'b1;
                        B_RESP  <= legal ? 2'b00 : 2'b10;
                        state   <= B_OUT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                B_OUT: begin
                    if (B_READY) begin
                        B_VALID <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_axi_responder.sv
// Self-checking bench for dram_axi_responder: vector table, directed corner sequences, random traffic vs. model.
module tb_dram_axi_responder;
    localparam int          DEPTH = 256;
    localparam logic [16:0] BASE  = 17'h10000;
    localparam int          LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        AR_VALID, AR_READY, R_VALID, R_READY;
    logic [16:0] AR_ADDR, AW_ADDR;
    logic [63:0] R_DATA, W_DATA;
    logic [1:0]  R_RESP, B_RESP;
    logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] mdl   [DEPTH];
    bit          known [DEPTH];
`ifdef DRAM_RAND_LAT_EN
    logic [7:0]  mlfsr;
`endif

    dram_axi_responder #(.DEPTH(DEPTH), .BASE(BASE), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0: return AR_READY;
            1: return R_VALID;
            2: return AW_READY;
            3: return W_READY;
            4: return B_VALID;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int s, input string name);
        int n;
        n = 0;
        while (!sig(s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!sig(s)) chk({name, "_timeout"}, 64'(sig(s)), 64'd1);
    endtask

    function automatic bit m_legal(input logic [16:0] a);
        int ai;
        ai = int'(a);
        return ai >= int'(BASE) && ai < int'(BASE) + 8 * DEPTH && ai % 8 == 0;
    endfunction

    function automatic int m_idx(input logic [16:0] a);
        return (int'(a) - int'(BASE)) / 8;
    endfunction

    function int exp_lat();
`ifdef DRAM_RAND_LAT_EN
        int l;
        l = 1 + int'(mlfsr[2:0]);
        mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
        return l;
`else
        return LAT;
`endif
    endfunction

    task automatic model_reset();
`ifdef DRAM_RAND_LAT_EN
        mlfsr = 8'hA5;
`endif
    endtask

    task automatic model_write(input logic [16:0] a, input logic [63:0] d);
        if (m_legal(a)) begin
            mdl[m_idx(a)]   = d;
            known[m_idx(a)] = 1'b1;
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ctl"}, 64'({AR_READY, R_VALID, R_RESP, AW_READY, W_READY, B_VALID, B_RESP}), 64'd0);
        chk({name, "_rdata"}, R_DATA, 64'd0);
    endtask

    // Caller is at a negedge with the DUT idle; lat is measured from the AR_VALID cycle to first R_VALID.
    task automatic do_read(input logic [16:0] a, input int hold,
                           output logic [63:0] d, output logic [1:0] r, output int lat);
        int t0;
        AR_ADDR  = a;
        AR_VALID = 1'b1;
        t0       = cyc;
        wait_for(0, "ar_ready");
        chk("ar_ready_cycle", 64'(cyc - t0), 64'd1);
        @(negedge clk);
        AR_VALID = 1'b0;
        wait_for(1, "r_valid");
        lat = cyc - t0;
        d   = R_DATA;
        r   = R_RESP;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_hold_valid", 64'(R_VALID), 64'd1);
            chk("r_hold_data", R_DATA, d);
            chk("r_hold_resp", 64'(R_RESP), 64'(r));
        end
        R_READY = 1'b1;
        @(negedge clk);
        R_READY = 1'b0;
        chk("r_valid_drop", 64'(R_VALID), 64'd0);
    endtask

    // blat is measured from the W handshake cycle to first B_VALID.
    task automatic do_write(input logic [16:0] a, input logic [63:0] wd,
                            output logic [1:0] r, output int blat);
        int t0, h;
        AW_ADDR  = a;
        AW_VALID = 1'b1;
        W_DATA   = wd;
        W_VALID  = 1'b1;
        t0       = cyc;
        wait_for(2, "aw_ready");
        chk("aw_ready_cycle", 64'(cyc - t0), 64'd1);
        @(negedge clk);
        AW_VALID = 1'b0;
        wait_for(3, "w_ready");
        chk("w_ready_cycle", 64'(cyc - t0), 64'd2);
        h = cyc;
        @(negedge clk);
        W_VALID = 1'b0;
        wait_for(4, "b_valid");
        blat = cyc - h;
        r    = B_RESP;
        B_READY = 1'b1;
        @(negedge clk);
        B_READY = 1'b0;
        chk("b_valid_drop", 64'(B_VALID), 64'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [16:0] addr;
        logic [63:0] data;
        logic [1:0]  resp;
        bit          cmp_data;
    } vec_t;

    vec_t        tbl [12];
    logic [63:0] d;
    logic [1:0]  r;
    int          lat, el, el2, h;
    logic [16:0] a;
    int          ai;
    logic [63:0] wd;

    initial begin
        tbl[0]  = '{1'b1, 17'h10008, 64'hDEADBEEF_01234567, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 17'h10008, 64'hDEADBEEF_01234567, 2'b00, 1'b1};
        tbl[2]  = '{1'b0, 17'h10004, 64'h0,                 2'b10, 1'b1};
        tbl[3]  = '{1'b1, 17'h107F8, 64'hCAFEF00D_55AA55AA, 2'b00, 1'b0};
        tbl[4]  = '{1'b1, 17'h10800, 64'h11111111_11111111, 2'b10, 1'b0};
        tbl[5]  = '{1'b0, 17'h107F8, 64'hCAFEF00D_55AA55AA, 2'b00, 1'b1};
        tbl[6]  = '{1'b1, 17'h10001, 64'h22222222_22222222, 2'b10, 1'b0};
        tbl[7]  = '{1'b0, 17'h10800, 64'h0,                 2'b10, 1'b1};
        tbl[8]  = '{1'b0, 17'h0FFF8, 64'h0,                 2'b10, 1'b1};
        tbl[9]  = '{1'b1, 17'h10000, 64'h01234567_89ABCDEF, 2'b00, 1'b0};
        tbl[10] = '{1'b0, 17'h10000, 64'h01234567_89ABCDEF, 2'b00, 1'b1};
        tbl[11] = '{1'b0, 17'h1FFF8, 64'h0,                 2'b10, 1'b1};

        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        AR_VALID = 0; AR_ADDR = '0; R_READY = 0;
        AW_VALID = 0; AW_ADDR = '0; W_VALID = 0; W_DATA = '0; B_READY = 0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset_held");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset_released");

        for (int i = 0; i < 12; i++) begin
            el = exp_lat();
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, r, lat);
                chk($sformatf("tbl%0d_bresp", i), 64'(r), 64'(tbl[i].resp));
                chk($sformatf("tbl%0d_blat", i), 64'(lat), 64'(el + 1));
                model_write(tbl[i].addr, tbl[i].data);
            end else begin
                do_read(tbl[i].addr, 0, d, r, lat);
                chk($sformatf("tbl%0d_rresp", i), 64'(r), 64'(tbl[i].resp));
                if (tbl[i].cmp_data) chk($sformatf("tbl%0d_rdata", i), d, tbl[i].data);
                chk($sformatf("tbl%0d_rlat", i), 64'(lat), 64'(el + 2));
            end
        end

        // Backpressure: R held for 10 cycles, then an immediate follow-up read.
        el = exp_lat();
        do_read(17'h10008, 10, d, r, lat);
        chk("bp_data", d, 64'hDEADBEEF_01234567);
        chk("bp_lat", 64'(lat), 64'(el + 2));
        el = exp_lat();
        do_read(17'h107F8, 0, d, r, lat);
        chk("bp_next_data", d, 64'hCAFEF00D_55AA55AA);

        // Simultaneous AR and AW: read wins and sees old data; write proceeds only after R handshake.
        AR_ADDR = 17'h10010; AW_ADDR = 17'h10010; W_DATA = 64'hA5A5_0000_FFFF_1234;
        el = exp_lat();
        do_write(17'h10010, 64'h0BAD_F00D_0000_0001, r, lat);
        model_write(17'h10010, 64'h0BAD_F00D_0000_0001);
        AR_ADDR = 17'h10010; AW_ADDR = 17'h10010; W_DATA = 64'hA5A5_0000_FFFF_1234;
        AR_VALID = 1'b1; AW_VALID = 1'b1; W_VALID = 1'b1;
        el  = exp_lat();
        el2 = exp_lat();
        wait_for(0, "sim_ar_ready");
        chk("sim_aw_not_first", 64'(AW_READY), 64'd0);
        @(negedge clk);
        AR_VALID = 1'b0;
        wait_for(1, "sim_r_valid");
        chk("sim_aw_during_r", 64'({AW_READY, W_READY}), 64'd0);
        chk("sim_old_data", R_DATA, 64'h0BAD_F00D_0000_0001);
        chk("sim_rresp", 64'(R_RESP), 64'd0);
        R_READY = 1'b1;
        @(negedge clk);
        R_READY = 1'b0;
        chk("sim_aw_after_rhs", 64'(AW_READY), 64'd0);
        wait_for(2, "sim_aw_ready");
        @(negedge clk);
        AW_VALID = 1'b0;
        wait_for(3, "sim_w_ready");
        h = cyc;
        @(negedge clk);
        W_VALID = 1'b0;
        wait_for(4, "sim_b_valid");
        chk("sim_blat", 64'(cyc - h), 64'(el2 + 1));
        chk("sim_bresp", 64'(B_RESP), 64'd0);
        B_READY = 1'b1;
        @(negedge clk);
        B_READY = 1'b0;
        model_write(17'h10010, 64'hA5A5_0000_FFFF_1234);
        el = exp_lat();
        do_read(17'h10010, 0, d, r, lat);
        chk("sim_new_data", d, 64'hA5A5_0000_FFFF_1234);

        // Reset while waiting for W data: no array update, outputs clear before the next edge.
        AW_ADDR = 17'h10008; AW_VALID = 1'b1; W_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_for(2, "rw_aw_ready");
        @(negedge clk);
        AW_VALID = 1'b0;
        wait_for(3, "rw_w_ready");
        #1 rst = 1'b1;
        #1 chk_idle_outputs("rst_in_w_ack");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        el = exp_lat();
        do_read(17'h10008, 0, d, r, lat);
        chk("rst_w_no_update", d, 64'hDEADBEEF_01234567);
        chk("rst_w_lat", 64'(lat), 64'(el + 2));

        // Reset while R_VALID is up with non-zero data.
        AR_ADDR = 17'h10008; AR_VALID = 1'b1;
        wait_for(0, "rr_ar_ready");
        @(negedge clk);
        AR_VALID = 1'b0;
        wait_for(1, "rr_r_valid");
        chk("rr_pre_data", R_DATA, 64'hDEADBEEF_01234567);
        #1 rst = 1'b1;
        #1 chk_idle_outputs("rst_in_r_out");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

`ifdef DRAM_RAND_LAT_EN
        for (int i = 0; i < 16; i++) begin
            el = exp_lat();
            do_read(17'h10008, 0, d, r, lat);
            chk("rand_lat_range", 64'(lat - 2 >= 1 && lat - 2 <= 8), 64'd1);
            chk("rand_lat_seq", 64'(lat), 64'(el + 2));
        end
`endif

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ai = int'(BASE) + 8 * int'($urandom_range(0, 15));
                6:       ai = int'(BASE) + 8 * int'($urandom_range(250, 255));
                7:       ai = int'(BASE) + 8 * int'($urandom_range(0, 255)) + int'($urandom_range(1, 7));
                8:       ai = int'(BASE) + 8 * DEPTH + 8 * int'($urandom_range(0, 1000));
                default: ai = 8 * int'($urandom_range(0, 8191));
            endcase
            a  = 17'(ai);
            el = exp_lat();
            if ($urandom_range(0, 1) == 1) begin
                wd = {$urandom, $urandom};
                do_write(a, wd, r, lat);
                chk("rnd_bresp", 64'(r), m_legal(a) ? 64'd0 : 64'd2);
                chk("rnd_blat", 64'(lat), 64'(el + 1));
                model_write(a, wd);
            end else begin
                do_read(a, int'($urandom_range(0, 3)), d, r, lat);
                chk("rnd_rresp", 64'(r), m_legal(a) ? 64'd0 : 64'd2);
                chk("rnd_rlat", 64'(lat), 64'(el + 2));
                if (!m_legal(a))
                    chk("rnd_rdata_illegal", d, 64'd0);
                else if (known[m_idx(a)])
                    chk("rnd_rdata", d, mdl[m_idx(a)]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "global timeout");
    end
endmodule
